// File: rtl/ascon_seq_ctrl.sv
// Sequencer for one Ascon-128 AEAD encryption through ascon_top: key load, AD blocks,
// PT blocks, ciphertext and tag capture. Define ASCON_SEQ_TRIG_EN to add the trig_o output.
module ascon_seq_ctrl #(
    parameter int pLEN_WIDTH = 16,
    parameter int pTIMEOUT   = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic [pLEN_WIDTH-1:0] ad_len_i,
    input  logic [pLEN_WIDTH-1:0] msg_len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_timeout_o,
    output logic                  req_o,
    output logic                  req_sel_o,
    input  logic                  blk_valid_i,
    output logic                  core_start_o,
    output logic                  core_key_valid_o,
    output logic                  core_valid_data_o,
    output logic                  core_last_o,
    output logic                  core_eot_o,
    output logic                  core_sel_o,
    output logic [4:0]            core_valid_bytes_o,
    input  logic                  core_ready_i,
    input  logic                  core_ct_valid_i,
    input  logic                  core_ready_tag_i,
    output logic                  core_read_o,
    output logic                  ct_capture_o,
    output logic                  tag_capture_o,
`ifdef ASCON_SEQ_TRIG_EN
    output logic                  trig_o,
`endif
    output logic [pLEN_WIDTH-5:0] blk_cnt_o
);

    localparam int LW = pLEN_WIDTH;
    localparam int BW = pLEN_WIDTH - 4;
    localparam int TW = $clog2(pTIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIM = TW'(pTIMEOUT - 1);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_KEY      = 4'd1;
    localparam logic [3:0] ST_KEY_WAIT = 4'd2;
    localparam logic [3:0] ST_AD_REQ   = 4'd3;
    localparam logic [3:0] ST_AD_SEND  = 4'd4;
    localparam logic [3:0] ST_PT_REQ   = 4'd5;
    localparam logic [3:0] ST_PT_SEND  = 4'd6;
    localparam logic [3:0] ST_CT_WAIT  = 4'd7;
    localparam logic [3:0] ST_TAG_WAIT = 4'd8;
    localparam logic [3:0] ST_FIN      = 4'd9;

    logic [3:0]    state;
    logic [3:0]    state_nxt;
    logic [LW-1:0] ad_len_q;
    logic [LW-1:0] msg_len_q;
    logic [BW-1:0] blk_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    logic          phase_pt;
    logic          send;
    logic [LW-1:0] cur_len;
    logic [LW-1:0] len_m1;
    logic          is_last;
    logic [4:0]    last_bytes;
    logic [4:0]    vbytes;
    logic          wait_st;
    logic          timeout_hit;
    logic          start_acc;
    logic          blk_clr;
    logic          blk_adv;

    // Block geometry of the current phase; msg_len=0 still yields one empty PT block.
    assign phase_pt   = (state == ST_PT_REQ) || (state == ST_PT_SEND) || (state == ST_CT_WAIT);
    assign send       = (state == ST_AD_SEND) || (state == ST_PT_SEND);
    assign cur_len    = phase_pt ? msg_len_q : ad_len_q;
    assign len_m1     = cur_len - LW'(1);
    assign is_last    = (cur_len == '0) || (blk_cnt == len_m1[LW-1:4]);
    assign last_bytes = {1'b0, len_m1[3:0]} + 5'd1;
    assign vbytes     = (cur_len == '0) ? 5'd0 : (is_last ? last_bytes : 5'd16);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start_i) state_nxt = ST_KEY;
            ST_KEY:      state_nxt = ST_KEY_WAIT;
            ST_KEY_WAIT: if (core_ready_i) state_nxt = (ad_len_q != '0) ? ST_AD_REQ : ST_PT_REQ;
            ST_AD_REQ:   if (blk_valid_i) state_nxt = ST_AD_SEND;
            ST_AD_SEND:  if (core_ready_i) state_nxt = is_last ? ST_PT_REQ : ST_AD_REQ;
            ST_PT_REQ:   if (blk_valid_i) state_nxt = ST_PT_SEND;
            ST_PT_SEND:  if (core_ready_i) state_nxt = ST_CT_WAIT;
            ST_CT_WAIT:  if (core_ct_valid_i) state_nxt = is_last ? ST_TAG_WAIT : ST_PT_REQ;
            ST_TAG_WAIT: if (core_ready_tag_i) state_nxt = ST_FIN;
            ST_FIN:      state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    assign wait_st     = (state != ST_IDLE) && (state != ST_KEY) && (state != ST_FIN);
    assign timeout_hit = wait_st && (state_nxt == state) && (tmo_cnt == TMO_LIM);
    assign start_acc   = (state == ST_IDLE) && start_i;

    assign blk_clr = start_acc || (state == ST_FIN)
                   || ((state == ST_KEY_WAIT) && core_ready_i)
                   || ((state == ST_AD_SEND) && core_ready_i && is_last);
    assign blk_adv = ((state == ST_AD_SEND) && core_ready_i && !is_last)
                   || ((state == ST_CT_WAIT) && core_ct_valid_i && !is_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ad_len_q  <= '0;
            msg_len_q <= '0;
            blk_cnt   <= '0;
            tmo_cnt   <= '0;
            err_q     <= 1'b0;
        end else if (timeout_hit) begin
            state   <= ST_IDLE;
            err_q   <= 1'b1;
            tmo_cnt <= '0;
            blk_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != '1) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (start_acc) begin
                ad_len_q  <= ad_len_i;
                msg_len_q <= msg_len_i;
                err_q     <= 1'b0;
            end
            if (blk_clr) begin
                blk_cnt <= '0;
            end else if (blk_adv) begin
                blk_cnt <= blk_cnt + BW'(1);
            end
        end
    end

    assign busy_o             = (state != ST_IDLE);
    assign done_o             = (state == ST_FIN);
    assign err_timeout_o      = err_q;
    assign req_o              = (state == ST_AD_REQ) || (state == ST_PT_REQ);
    assign req_sel_o          = (state == ST_PT_REQ);
    assign core_start_o       = (state == ST_KEY);
    assign core_key_valid_o   = (state == ST_KEY);
    assign core_valid_data_o  = send;
    assign core_sel_o         = (state == ST_PT_SEND);
    assign core_last_o        = send && is_last;
    assign core_eot_o         = (state == ST_PT_SEND) && is_last;
    assign core_valid_bytes_o = send ? vbytes : 5'd0;
    assign ct_capture_o       = (state == ST_CT_WAIT) && core_ct_valid_i;
    assign tag_capture_o      = (state == ST_TAG_WAIT) && core_ready_tag_i;
    assign core_read_o        = ct_capture_o || tag_capture_o;
    assign blk_cnt_o          = blk_cnt;

`ifdef ASCON_SEQ_TRIG_EN
    logic trig_q;

    // Trigger window spans first data transfer through tag capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_q <= 1'b0;
        end else if (timeout_hit || tag_capture_o || (state == ST_IDLE)) begin
            trig_q <= 1'b0;
        end else if (send && core_ready_i) begin
            trig_q <= 1'b1;
        end
    end

    assign trig_o = trig_q;
`endif

endmodule

// File: tb/tb_ascon_seq_ctrl.sv
// Self-checking bench for ascon_seq_ctrl: randomized host/core handshakes checked
// against a block-list model derived from the programmed byte lengths.
module tb_ascon_seq_ctrl;

    localparam int LW  = 16;
    localparam int BW  = LW - 4;
    localparam int TMO = 1023;

    typedef struct {
        bit sel;
        int bytes;
        bit last;
        bit eot;
        int idx;
    } xfer_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start_i;
    logic [LW-1:0] ad_len_i;
    logic [LW-1:0] msg_len_i;
    logic          busy_o;
    logic          done_o;
    logic          err_timeout_o;
    logic          req_o;
    logic          req_sel_o;
    logic          blk_valid_i;
    logic          core_start_o;
    logic          core_key_valid_o;
    logic          core_valid_data_o;
    logic          core_last_o;
    logic          core_eot_o;
    logic          core_sel_o;
    logic [4:0]    core_valid_bytes_o;
    logic          core_ready_i;
    logic          core_ct_valid_i;
    logic          core_ready_tag_i;
    logic          core_read_o;
    logic          ct_capture_o;
    logic          tag_capture_o;
    logic [BW-1:0] blk_cnt_o;
`ifdef ASCON_SEQ_TRIG_EN
    logic          trig_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ascon_seq_ctrl #(.pLEN_WIDTH(LW), .pTIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i),
        .ad_len_i(ad_len_i), .msg_len_i(msg_len_i),
        .busy_o(busy_o), .done_o(done_o), .err_timeout_o(err_timeout_o),
        .req_o(req_o), .req_sel_o(req_sel_o), .blk_valid_i(blk_valid_i),
        .core_start_o(core_start_o), .core_key_valid_o(core_key_valid_o),
        .core_valid_data_o(core_valid_data_o), .core_last_o(core_last_o),
        .core_eot_o(core_eot_o), .core_sel_o(core_sel_o),
        .core_valid_bytes_o(core_valid_bytes_o), .core_ready_i(core_ready_i),
        .core_ct_valid_i(core_ct_valid_i), .core_ready_tag_i(core_ready_tag_i),
        .core_read_o(core_read_o), .ct_capture_o(ct_capture_o),
        .tag_capture_o(tag_capture_o),
`ifdef ASCON_SEQ_TRIG_EN
        .trig_o(trig_o),
`endif
        .blk_cnt_o(blk_cnt_o)
    );

    // All outputs packed with err_timeout_o in bit 0.
    function automatic logic [63:0] out_vec();
        logic [63:0] v;
        v = 64'({busy_o, done_o, req_o, req_sel_o, core_start_o, core_key_valid_o,
                 core_valid_data_o, core_last_o, core_eot_o, core_sel_o, core_valid_bytes_o,
                 core_read_o, ct_capture_o, tag_capture_o, blk_cnt_o, err_timeout_o});
`ifdef ASCON_SEQ_TRIG_EN
        v[63] = trig_o;
`endif
        return v;
    endfunction

    task automatic drive_idle();
        start_i          = 1'b0;
        ad_len_i         = '0;
        msg_len_i        = '0;
        blk_valid_i      = 1'b0;
        core_ready_i     = 1'b0;
        core_ct_valid_i  = 1'b0;
        core_ready_tag_i = 1'b0;
    endtask

    // One full operation with randomized handshakes; per-transfer fields checked against the block list.
    task automatic run_op(input int ad, input int msg, input bit inject,
                          output int n_ad, output int n_pt, output int n_ct,
                          output int n_tag, output int n_done, output int n_eot);
        xfer_t q[$];
        xfer_t h;
        int nad, npt, pend, n_key, n_read, cyc;
        bit injected, ad_req_seen, finished, exp_trig, ct_ack, tag_ack;
        nad = (ad + 15) / 16;
        npt = (msg == 0) ? 1 : (msg + 15) / 16;
        for (int i = 0; i < nad; i++)
            q.push_back('{1'b0, (i == nad - 1) ? ad - 16 * i : 16, i == nad - 1, 1'b0, i});
        for (int i = 0; i < npt; i++)
            q.push_back('{1'b1, (msg == 0) ? 0 : ((i == npt - 1) ? msg - 16 * i : 16),
                          i == npt - 1, i == npt - 1, i});
        n_ad = 0; n_pt = 0; n_ct = 0; n_tag = 0; n_done = 0; n_eot = 0;
        pend = 0; n_key = 0; n_read = 0; injected = 0; ad_req_seen = 0;
        finished = 0; exp_trig = 0;

        @(posedge clk); #1;
        drive_idle();
        start_i   = 1'b1;
        ad_len_i  = LW'(ad);
        msg_len_i = LW'(msg);
        @(posedge clk); #1;
        start_i   = 1'b0;
        ad_len_i  = LW'($urandom);
        msg_len_i = LW'($urandom);

        cyc = 0;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            ct_ack = 0;
            tag_ack = 0;
            checks++;
            if (busy_o !== 1'b1) begin failures++; $display("FAIL busy_during_op: got %b want 1", busy_o); end
            checks++;
            if (err_timeout_o !== 1'b0) begin failures++; $display("FAIL err_during_op: got %b want 0", err_timeout_o); end
`ifdef ASCON_SEQ_TRIG_EN
            checks++;
            if (trig_o !== exp_trig) begin failures++; $display("FAIL trig: got %b want %b", trig_o, exp_trig); end
`endif
            if (core_start_o) begin
                n_key++;
                checks++;
                if (core_key_valid_o !== 1'b1) begin failures++; $display("FAIL key_valid: got %b want 1", core_key_valid_o); end
            end
            if (req_o) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL req_extra: got req with no block pending, want none");
                end else if (req_sel_o !== q[0].sel) begin
                    failures++; $display("FAIL req_sel: got %b want %b", req_sel_o, q[0].sel);
                end
                if (q.size() != 0 && !q[0].sel) ad_req_seen = 1;
            end
            if (core_valid_data_o) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL xfer_extra: got valid_data with no block pending, want none");
                end else begin
                    h = q[0];
                    if ({core_sel_o, core_last_o, core_eot_o, core_valid_bytes_o, blk_cnt_o} !==
                        {h.sel, h.last, h.eot, 5'(h.bytes), BW'(h.idx)}) begin
                        failures++;
                        $display("FAIL xfer_fields: got sel=%b last=%b eot=%b bytes=%0d blk=%0d want sel=%b last=%b eot=%b bytes=%0d blk=%0d",
                                 core_sel_o, core_last_o, core_eot_o, core_valid_bytes_o, blk_cnt_o,
                                 h.sel, h.last, h.eot, h.bytes, h.idx);
                    end
                    if (core_ready_i) begin
                        void'(q.pop_front());
                        if (h.sel) begin n_pt++; pend++; end else n_ad++;
                        if (h.eot) n_eot++;
                        exp_trig = 1;
                    end
                end
            end
            if (ct_capture_o) begin
                n_ct++;
                checks++;
                if (pend < 1) begin failures++; $display("FAIL ct_early: got capture with %0d pending, want >=1", pend); end
                pend--;
                ct_ack = 1;
            end
            if (tag_capture_o) begin
                n_tag++;
                checks++;
                if (n_ct != npt || q.size() != 0) begin
                    failures++; $display("FAIL tag_early: got tag after %0d ct, want after %0d", n_ct, npt);
                end
                tag_ack = 1;
                exp_trig = 0;
            end
            if (core_read_o) n_read++;
            if (done_o) begin n_done++; finished = 1; end

            @(posedge clk); #1;
            start_i = 1'b0;
            if (inject && !injected && ad_req_seen) begin
                injected  = 1;
                start_i   = 1'b1;
                ad_len_i  = LW'(7);
                msg_len_i = LW'(99);
            end
            core_ready_i = ($urandom_range(0, 3) != 0);
            blk_valid_i  = ($urandom_range(0, 2) != 0);
            if (ct_ack) core_ct_valid_i = 1'b0;
            else if (pend > 0 && $urandom_range(0, 1) != 0) core_ct_valid_i = 1'b1;
            if (tag_ack) core_ready_tag_i = 1'b0;
            else if (n_pt == npt && $urandom_range(0, 1) != 0) core_ready_tag_i = 1'b1;
        end
        checks++;
        if (!finished) begin failures++; $display("FAIL done_timeout: got no done in 3000 cycles, want done"); end
        @(negedge clk);
        checks++;
        if ({done_o, busy_o} !== 2'b00) begin failures++; $display("FAIL after_done: got done=%b busy=%b want 0 0", done_o, busy_o); end
        checks++;
        if (n_key != 1) begin failures++; $display("FAIL key_count: got %0d want 1", n_key); end
        checks++;
        if (n_read != npt + 1) begin failures++; $display("FAIL read_count: got %0d want %0d", n_read, npt + 1); end
        checks++;
        if (q.size() != 0) begin failures++; $display("FAIL blocks_left: got %0d want 0", q.size()); end
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_vec() !== 64'd0) begin failures++; $display("FAIL reset_outputs: got %h want 0", out_vec()); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_vec() !== 64'd0) begin failures++; $display("FAIL post_reset_outputs: got %h want 0", out_vec()); end
    endtask

    task automatic test_single_block();
        int a, p, c, t, d, e;
        run_op(16, 16, 0, a, p, c, t, d, e);
        checks++;
        if ({a, p, c, t, d, e} !== {32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1}) begin
            failures++; $display("FAIL single_counts: got ad=%0d pt=%0d ct=%0d tag=%0d done=%0d eot=%0d want 1 each", a, p, c, t, d, e);
        end
    endtask

    task automatic test_pt_only();
        int a, p, c, t, d, e;
        run_op(0, 35, 0, a, p, c, t, d, e);
        checks++;
        if ({a, p, c, t, d, e} !== {32'd0, 32'd3, 32'd3, 32'd1, 32'd1, 32'd1}) begin
            failures++; $display("FAIL pt_only_counts: got ad=%0d pt=%0d ct=%0d tag=%0d done=%0d eot=%0d want 0 3 3 1 1 1", a, p, c, t, d, e);
        end
    endtask

    task automatic test_ad_tail();
        int a, p, c, t, d, e;
        run_op(20, 0, 0, a, p, c, t, d, e);
        checks++;
        if ({a, p, c, t, d, e} !== {32'd2, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1}) begin
            failures++; $display("FAIL ad_tail_counts: got ad=%0d pt=%0d ct=%0d tag=%0d done=%0d eot=%0d want 2 1 1 1 1 1", a, p, c, t, d, e);
        end
    endtask

    task automatic test_timeout();
        int dones;
        dones = 0;
        @(posedge clk); #1;
        drive_idle();
        start_i  = 1'b1;
        ad_len_i = LW'(16);
        msg_len_i = LW'(16);
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (done_o) dones++;
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if ({err_timeout_o, busy_o} !== 2'b01) begin
            failures++; $display("FAIL timeout_early: got err=%b busy=%b want 0 1", err_timeout_o, busy_o);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_vec() !== 64'd1) begin failures++; $display("FAIL timeout_outputs: got %h want 1", out_vec()); end
        checks++;
        if (dones != 0) begin failures++; $display("FAIL timeout_done: got %0d done pulses want 0", dones); end
        repeat (3) @(negedge clk);
        checks++;
        if (err_timeout_o !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %b want 1", err_timeout_o); end
        test_single_block();
    endtask

    task automatic test_reset_mid_op();
        int a, p, c, t, d, e;
        bit found;
        found = 0;
        @(posedge clk); #1;
        start_i = 1'b1;
        ad_len_i = '0;
        msg_len_i = LW'(40);
        @(posedge clk); #1;
        start_i = 1'b0;
        core_ready_i = 1'b1;
        blk_valid_i = 1'b1;
        core_ct_valid_i = 1'b1;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            checks++;
            if (done_o !== 1'b0) begin failures++; $display("FAIL mid_done: got %b want 0", done_o); end
            if (core_valid_data_o && blk_cnt_o == BW'(1)) found = 1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL mid_reach: got no PT_SEND of block 1 want reached"); end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (out_vec() !== 64'd0) begin failures++; $display("FAIL async_reset: got %h want 0", out_vec()); end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        checks++;
        if (out_vec() !== 64'd0) begin failures++; $display("FAIL reset_hold: got %h want 0", out_vec()); end
        reset_n = 1'b1;
        run_op(0, 16, 0, a, p, c, t, d, e);
        checks++;
        if ({p, c, t, d} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
            failures++; $display("FAIL post_reset_op: got pt=%0d ct=%0d tag=%0d done=%0d want 1 each", p, c, t, d);
        end
    endtask

    task automatic test_restart_ignored();
        int a, p, c, t, d, e;
        run_op(40, 20, 1, a, p, c, t, d, e);
        checks++;
        if ({a, p, c, d} !== {32'd3, 32'd2, 32'd2, 32'd1}) begin
            failures++; $display("FAIL restart_counts: got ad=%0d pt=%0d ct=%0d done=%0d want 3 2 2 1", a, p, c, d);
        end
    endtask

    task automatic test_random();
        int a, p, c, t, d, e, ad, msg, nad, npt;
        for (int k = 0; k < 8; k++) begin
            ad  = $urandom_range(0, 70);
            msg = $urandom_range(0, 70);
            nad = (ad + 15) / 16;
            npt = (msg == 0) ? 1 : (msg + 15) / 16;
            run_op(ad, msg, 0, a, p, c, t, d, e);
            checks++;
            if (a != nad || p != npt || c != npt || t != 1 || d != 1) begin
                failures++;
                $display("FAIL random_counts ad_len=%0d msg_len=%0d: got ad=%0d pt=%0d ct=%0d tag=%0d done=%0d want %0d %0d %0d 1 1",
                         ad, msg, a, p, c, t, d, nad, npt, npt);
            end
        end
    endtask

    initial begin
        drive_idle();
        reset_n = 1'b0;
        test_reset();
        test_single_block();
        test_pt_only();
        test_ad_tail();
        test_timeout();
        test_reset_mid_op();
        test_restart_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
